// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: owns the fetch PC, issues in-order word reads and queues the
// returned words with their PCs for decode. Optional macro FETCH_BYPASS_EN: empty-FIFO bypass.
module inst_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [31:0]   fpc;
    logic [31:0]   rsp_pc;
    logic [LW-1:0] level;
    logic [LW-1:0] outstanding;
    logic [LW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   buf_inst [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];

    logic [LW:0]   credit;
    logic [31:0]   redirect_aligned;
    logic [LW-1:0] rvalid_n;
    logic          grant;
    logic          fifo_valid;
    logic          rsp_live;
    logic          bypass;
    logic          push;
    logic          pop;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    // Occupied entries plus in-flight reads never exceed DEPTH, so a push always has room.
    assign credit     = {1'b0, level} + {1'b0, outstanding};
    assign imem_req   = !rst && !redirect && (credit < (LW+1)'(DEPTH));
    assign imem_addr  = fpc;
    assign grant      = imem_req && imem_gnt;
    assign fifo_valid = (level != '0);
    assign rsp_live   = imem_rvalid && (drop_cnt == '0) && !redirect;
    assign rvalid_n   = LW'(imem_rvalid);
    assign fifo_level = level;

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_live && !fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = fifo_valid && inst_ready && !redirect;
    assign push = rsp_live && !(bypass && inst_ready);

    always_comb begin
        inst_valid = fifo_valid || bypass;
        inst       = '0;
        inst_pc    = '0;
        if (fifo_valid) begin
            inst    = buf_inst[rd_ptr];
            inst_pc = buf_pc[rd_ptr];
        end else if (bypass) begin
            inst    = imem_rdata;
            inst_pc = rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect) begin
            // Every read still in flight after this cycle belongs to the old path.
            fpc         <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            outstanding <= outstanding - rvalid_n;
            drop_cnt    <= outstanding - rvalid_n;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (grant)
                fpc <= fpc + 32'd4;
            if (imem_rvalid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - LW'(1);
            if (rsp_live)
                rsp_pc <= rsp_pc + 32'd4;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level       <= level + LW'(push) - LW'(pop);
            outstanding <= outstanding + LW'(grant) - rvalid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outstanding != '0));

endmodule
